// File: rtl/nios2_pio_in_capture_pkg.sv
// nios2_pio_pkg
// Shared constants for the Nios II input PIO: Avalon word addresses of the
// register map and the encodings of the edge-capture condition.
// No ports. Optional build macro used by the PIO: NIOS2_PIO_IN_SYNC_EN.
package nios2_pio_pkg;

  // Word addresses on the 3-bit Avalon address bus
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  // Capture condition encodings for the EDGE_TYPE parameter
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios2_pio_in_capture_if.sv
// nios2_pio_in_capture_if
// Avalon-MM slave bus of the input PIO, bundled with its level interrupt.
//   address    3-bit word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit registered read data
//   irq        level interrupt request, active high
// master: the Nios II / bus side. slave: the PIO.
interface nios2_pio_in_capture_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios2_pio_in_capture_edge_det.sv
// nios2_pio_edge_det
// Samples the external input vector, keeps a one-clock delayed copy and
// produces the per-bit edge pulse selected by EDGE_TYPE.
// Macro NIOS2_PIO_IN_SYNC_EN: when defined, in_port_i passes through a
// two-flop synchroniser before becoming data_in_o; otherwise data_in_o is
// in_port_i directly (for inputs already synchronous to clk).
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   in_port_i  external input vector
//   data_in_o  sampled input as seen by the register file
//   edge_o     one-clock edge pulse per bit
module nios2_pio_edge_det
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port_i,
  output logic [WIDTH-1:0] data_in_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] d1_q;

`ifdef NIOS2_PIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two metastability flops; the second stage is the clean sampled value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port_i;
      sync2_q <= sync1_q;
    end
  end

  assign data_in_o = sync2_q;
`else
  assign data_in_o = in_port_i;
`endif

  // Previous-cycle copy of the sampled input, reset to 0 so a high input
  // after reset release shows up as a rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_q <= '0;
    end else begin
      d1_q <= data_in_o;
    end
  end

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign edge_o = ~data_in_o & d1_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_o = data_in_o ^ d1_q;
    end else begin : g_rising
      assign edge_o = data_in_o & ~d1_q;
    end
  endgenerate

endmodule

// File: rtl/nios2_pio_in_capture.sv
// nios2_pio_in_capture
// Avalon-MM slave input PIO with sticky per-bit edge capture, interrupt
// mask (with set/clear aliases) and a level IRQ.
// Macro NIOS2_PIO_IN_SYNC_EN: enables the two-flop input synchroniser
// (edge latency 3 clk instead of 1 clk).
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_port  external input vector, WIDTH bits
//   bus      Avalon slave: address, chipselect, write_n, writedata,
//            readdata (1-clk latency), irq
// Read map: 0 data_in, 2 irq_mask, 3 edge_capture, others 0.
// Write map: 2 mask load, 3 edge write-1-to-clear, 4 mask set, 5 mask clear.
module nios2_pio_in_capture
  import nios2_pio_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               EDGE_TYPE  = EDGE_RISING,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  nios2_pio_in_capture_if.slave bus
);

  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] edgeDet;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic [WIDTH-1:0] edgeCapture_q, edgeCapture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             wrStrobe;
  logic             unusedWritedata;

  nios2_pio_edge_det #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port_i (in_port),
    .data_in_o (dataIn),
    .edge_o    (edgeDet)
  );

  assign wrStrobe        = bus.chipselect & ~bus.write_n;
  assign wdata           = bus.writedata[WIDTH-1:0];
  assign unusedWritedata = ^bus.writedata;

  // Next-state for mask, capture and read data. The capture update clears
  // first and ORs the new edges last, so a same-cycle edge wins over a clear.
  always_comb begin
    irqMask_d  = irqMask_q;
    clr        = '0;
    readdata_d = 32'd0;

    if (wrStrobe) begin
      case (bus.address)
        ADDR_MASK: irqMask_d = wdata;
        ADDR_SET:  irqMask_d = irqMask_q | wdata;
        ADDR_CLR:  irqMask_d = irqMask_q & ~wdata;
        ADDR_EDGE: clr       = wdata;
        default:   irqMask_d = irqMask_q;
      endcase
    end

    edgeCapture_d = (edgeCapture_q & ~clr) | edgeDet;

    // Read mux runs every cycle regardless of chipselect; reads have no
    // side effects, so this is harmless
    case (bus.address)
      ADDR_DATA: readdata_d = 32'(dataIn);
      ADDR_MASK: readdata_d = 32'(irqMask_q);
      ADDR_EDGE: readdata_d = 32'(edgeCapture_q);
      default:   readdata_d = 32'd0;
    endcase
  end

  // Register file state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqMask_q     <= RESET_MASK;
      edgeCapture_q <= '0;
      readdata_q    <= 32'd0;
    end else begin
      irqMask_q     <= irqMask_d;
      edgeCapture_q <= edgeCapture_d;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  // Driven only from registers, so in_port glitches cannot reach irq
  assign bus.irq      = |(edgeCapture_q & irqMask_q);

endmodule
